// File: rtl/bcd_scan_display.sv
// Four-digit multiplexed seven-segment driver with a shadowed BCD word that is swapped in only at scan-frame boundaries.
// Optional leading-zero blanking is enabled by defining LZ_BLANK_EN.
module bcd_scan_display #(
  parameter int unsigned SCAN_DIV = 50000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] bcd_in,
  input  logic        load,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        pending,
  output logic        bcd_err
);

  localparam int unsigned PW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(SCAN_DIV - 1);

  logic [PW-1:0] presc_r;
  logic [1:0]    idx_r;
  logic [15:0]   disp_r;
  logic [15:0]   shadow_r;

  logic          tick_s;
  logic          boundary_s;
  logic [1:0]    idx_next_s;
  logic [15:0]   disp_next_s;
  logic          pending_next_s;
  logic [3:0]    digit_s;
  logic [3:0]    blank_s;
  logic [6:0]    seg_next_s;
  logic [3:0]    an_next_s;

  function automatic logic [6:0] decode_seg(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b1000000;
      4'd1:    s = 7'b1111001;
      4'd2:    s = 7'b0100100;
      4'd3:    s = 7'b0110000;
      4'd4:    s = 7'b0011001;
      4'd5:    s = 7'b0010010;
      4'd6:    s = 7'b0000010;
      4'd7:    s = 7'b1111000;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0010000;
      default: s = 7'b0111111;
    endcase
    return s;
  endfunction

  function automatic logic word_has_err(input logic [15:0] w);
    return (w[15:12] > 4'd9) || (w[11:8] > 4'd9) || (w[7:4] > 4'd9) || (w[3:0] > 4'd9);
  endfunction

  assign tick_s     = (presc_r == PRESC_MAX);
  assign boundary_s = tick_s && (idx_r == 2'd3);
  assign idx_next_s = idx_r + 2'd1;

  // Display/pending update: a load landing on the boundary bypasses the shadow.
  always_comb begin
    disp_next_s    = disp_r;
    pending_next_s = pending;
    if (boundary_s && load) begin
      disp_next_s    = bcd_in;
      pending_next_s = 1'b0;
    end else if (boundary_s && pending) begin
      disp_next_s    = shadow_r;
      pending_next_s = 1'b0;
    end else if (load) begin
      pending_next_s = 1'b1;
    end else begin
      pending_next_s = pending;
    end
  end

  // Leading-zero blank mask computed from the post-swap word.
  always_comb begin
    blank_s = 4'b0000;
`ifdef LZ_BLANK_EN
    blank_s[3] = (disp_next_s[15:12] == 4'd0);
    blank_s[2] = blank_s[3] && (disp_next_s[11:8] == 4'd0);
    blank_s[1] = blank_s[2] && (disp_next_s[7:4] == 4'd0);
`else
    blank_s = 4'b0000;
`endif
  end

  // Segment and anode values for the digit selected on the next tick.
  always_comb begin
    digit_s   = 4'd0;
    an_next_s = 4'b1111;
    case (idx_next_s)
      2'd0:    begin digit_s = disp_next_s[3:0];   an_next_s = 4'b1110; end
      2'd1:    begin digit_s = disp_next_s[7:4];   an_next_s = 4'b1101; end
      2'd2:    begin digit_s = disp_next_s[11:8];  an_next_s = 4'b1011; end
      2'd3:    begin digit_s = disp_next_s[15:12]; an_next_s = 4'b0111; end
      default: begin digit_s = 4'd0;               an_next_s = 4'b1111; end
    endcase
    if (blank_s[idx_next_s]) begin
      seg_next_s = 7'h7F;
      an_next_s  = 4'hF;
    end else begin
      seg_next_s = decode_seg(digit_s);
    end
  end

  // Scan state, shadow/display words and registered outputs.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      presc_r  <= '0;
      idx_r    <= 2'd3;
      disp_r   <= 16'h0000;
      shadow_r <= 16'h0000;
      pending  <= 1'b0;
      bcd_err  <= 1'b0;
      seg      <= 7'h7F;
      an       <= 4'hF;
    end else begin
      presc_r <= tick_s ? '0 : presc_r + PW'(1);
      if (tick_s) begin
        idx_r <= idx_next_s;
        seg   <= seg_next_s;
        an    <= an_next_s;
      end
      if (load) begin
        shadow_r <= bcd_in;
      end
      disp_r  <= disp_next_s;
      pending <= pending_next_s;
      bcd_err <= word_has_err(disp_next_s);
    end
  end

endmodule

// File: tb/tb_bcd_scan_display.sv
// Directed self-checking bench for bcd_scan_display with SCAN_DIV=4 (boundaries at edges 4, 20, 36, ...).
// Expected values follow LZ_BLANK_EN when it is defined for the build.
module tb_bcd_scan_display;

  logic        clk;
  logic        rst;
  logic [15:0] bcd_in;
  logic        load;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        pending;
  logic        bcd_err;

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  bcd_scan_display #(.SCAN_DIV(4)) dut (
    .clk(clk), .rst(rst), .bcd_in(bcd_in), .load(load),
    .seg(seg), .an(an), .pending(pending), .bcd_err(bcd_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s (edge %0d): observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic go_to(input int k);
    while (cyc < k) begin
      @(posedge clk);
      cyc++;
    end
    #1;
  endtask

  task automatic do_load(input logic [15:0] d);
    bcd_in = d;
    load   = 1'b1;
    go_to(cyc + 1);
    load   = 1'b0;
  endtask

  task automatic chk_out(input string tag, input logic [3:0] e_an, input logic [6:0] e_seg);
    chk({tag, ".an"}, {12'h000, an}, {12'h000, e_an});
    chk({tag, ".seg"}, {9'h000, seg}, {9'h000, e_seg});
  endtask

  initial begin
    rst = 1'b0; load = 1'b0; bcd_in = 16'h0000;
    #8;
    chk_out("in_reset", 4'hF, 7'h7F);
    chk("in_reset.pending", {15'h0, pending}, 16'h0);
    #4 rst = 1'b1;
    cyc = 0;

    go_to(1);  chk_out("post_rst_e1", 4'hF, 7'h7F);
    go_to(3);  chk_out("post_rst_e3", 4'hF, 7'h7F);
    chk("post_rst.pending", {15'h0, pending}, 16'h0);
    go_to(4);  chk_out("first_digit", 4'hE, 7'h40);
    chk("first_digit.bcd_err", {15'h0, bcd_err}, 16'h0);

    do_load(16'h1234);
    chk("load1234.pending", {15'h0, pending}, 16'h1);
    go_to(8);  chk_out("old_d1", 4'hD, 7'h40);
    go_to(19); chk("pre_swap.pending", {15'h0, pending}, 16'h1);
    go_to(20); chk_out("w1234_d0", 4'hE, 7'h19);
    chk("swap.pending", {15'h0, pending}, 16'h0);
    go_to(24); chk_out("w1234_d1", 4'hD, 7'h30);
    go_to(28); chk_out("w1234_d2", 4'hB, 7'h24);
    go_to(32); chk_out("w1234_d3", 4'h7, 7'h79);

    go_to(40); do_load(16'h5678);
    chk("load5678.pending", {15'h0, pending}, 16'h1);
    go_to(44); chk_out("tear_old_d2", 4'hB, 7'h24);
    go_to(45); do_load(16'h9999);
    go_to(48); chk_out("tear_old_d3", 4'h7, 7'h79);
    chk("tear.pending", {15'h0, pending}, 16'h1);
    go_to(52); chk_out("w9999_d0", 4'hE, 7'h10);
    chk("w9999.pending", {15'h0, pending}, 16'h0);
    go_to(56); chk_out("w9999_d1", 4'hD, 7'h10);
    go_to(64); chk_out("w9999_d3", 4'h7, 7'h10);

    go_to(67); do_load(16'h4321);
    chk_out("coincide_d0", 4'hE, 7'h79);
    chk("coincide.pending", {15'h0, pending}, 16'h0);
    do_load(16'h00A7);
    go_to(72); chk_out("w4321_d1", 4'hD, 7'h24);
    go_to(83); chk("pre_dash.bcd_err", {15'h0, bcd_err}, 16'h0);
    go_to(84); chk_out("w00A7_d0", 4'hE, 7'h78);
    chk("w00A7.bcd_err", {15'h0, bcd_err}, 16'h1);
    go_to(88); chk_out("w00A7_dash", 4'hD, 7'h3F);
`ifdef LZ_BLANK_EN
    go_to(92); chk_out("w00A7_d2", 4'hF, 7'h7F);
    go_to(96); chk_out("w00A7_d3", 4'hF, 7'h7F);
`else
    go_to(92); chk_out("w00A7_d2", 4'hB, 7'h40);
    go_to(96); chk_out("w00A7_d3", 4'h7, 7'h40);
`endif

    go_to(97); do_load(16'h0007);
    chk("err_hold.bcd_err", {15'h0, bcd_err}, 16'h1);
    go_to(100); chk_out("w0007_d0", 4'hE, 7'h78);
    chk("err_clear.bcd_err", {15'h0, bcd_err}, 16'h0);
`ifdef LZ_BLANK_EN
    go_to(104); chk_out("w0007_d1", 4'hF, 7'h7F);
    go_to(108); chk_out("w0007_d2", 4'hF, 7'h7F);
    go_to(112); chk_out("w0007_d3", 4'hF, 7'h7F);
`else
    go_to(104); chk_out("w0007_d1", 4'hD, 7'h40);
    go_to(108); chk_out("w0007_d2", 4'hB, 7'h40);
    go_to(112); chk_out("w0007_d3", 4'h7, 7'h40);
`endif

    do_load(16'h8888);
    go_to(114);
    chk("pre_reset.pending", {15'h0, pending}, 16'h1);
    #2 rst = 1'b0;
    #1;
    chk_out("async_reset", 4'hF, 7'h7F);
    chk("async_reset.pending", {15'h0, pending}, 16'h0);
    #2 rst = 1'b1;
    cyc = 0;
    go_to(3);  chk_out("rerun_dark", 4'hF, 7'h7F);
    go_to(4);  chk_out("rerun_d0", 4'hE, 7'h40);
    go_to(20); chk_out("shadow_discard", 4'hE, 7'h40);
    chk("shadow_discard.pending", {15'h0, pending}, 16'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/bcd_scan_display.md
# bcd_scan_display

Four-digit multiplexed seven-segment driver consuming the 4-bit BCD outputs of cascaded decade counter stages. It captures a 16-bit BCD word on a load strobe and holds it in a shadow register. It swaps the word into the display register only at a scan-frame boundary, so a frame never mixes old and new digits. It then scans the digits onto a common-anode display at a programmable refresh rate.

## Interface
- SCAN_DIV, 50000: clock cycles each digit is lit; legal range 2..2^20.
- clk  input  1  system clock, all state updates on rising edge
- rst  input  1  asynchronous active-low reset
- bcd_in  input  16  {d3,d2,d1,d0} BCD digits, d3 most significant
- load  input  1  capture strobe; bcd_in sampled on any clk edge with load=1
- seg  output  7  active-low segments {g,f,e,d,c,b,a}, registered
- an  output  4  active-low digit enables, an[i] drives digit i, registered
- pending  output  1  shadow word captured but not yet displayed
- bcd_err  output  1  display register holds a nibble > 9

## Operation
- Prescaler counts from 0 to SCAN_DIV-1, then wraps. tick = (presc == SCAN_DIV-1).
- On tick, the 2-bit digit index idx advances modulo 4. Sequence is 0,1,2,3,0…
- Frame boundary = tick while idx==3, i.e. the edge that selects digit 0.
- load=1: shadow <= bcd_in, pending <= 1. Multiple loads before a boundary: last one wins.
- Frame boundary with pending=1: disp <= shadow, pending <= 0.
- Simultaneous load and frame boundary: disp <= bcd_in directly, shadow <= bcd_in, pending <= 0. The new word shows on digit 0 in this same edge.
- On tick, the outputs for the newly selected digit n are registered:
  - an <= one-cold vector with bit n = 0.
  - seg <= decode(disp nibble n), using the post-swap disp at a boundary.
- Decode (active-low): 0=1000000, 1=1111001, 2=0100100, 3=0110000, 4=0011001, 5=0010010, 6=0000010, 7=1111000, 8=0000000, 9=0010000, 10..15=0111111 (dash, only g lit).
- bcd_err <= 1 when any disp nibble > 9. It is updated on the same edge disp changes.

## Timing
- Reset values:
  - seg=7'h7F, an=4'hF (all dark), pending=0, bcd_err=0.
  - presc=0, idx=3, disp=0, shadow=0.
- First lit digit: digit 0, showing "0", from edge SCAN_DIV after reset release.
- Each digit is lit for exactly SCAN_DIV cycles. Frame period is 4*SCAN_DIV cycles.
- Load-to-display latency: from 1 to 4*SCAN_DIV cycles, set by the frame-boundary position. pending is high from the edge after load until the swap edge.
- Reset asserted mid-scan: all state returns to reset values immediately (asynchronous). Any shadow contents are discarded.
- Only one an bit is ever low. On every tick, an and seg change on the same edge (no ghosting gap).

## Configuration
- LZ_BLANK_EN defined: leading-zero blanking.
  - Digit i (i=3,2,1) is blanked when it and all higher digits are 0.
  - A blanked digit drives an=4'hF and seg=7'h7F for its slot, but the slot timing is unchanged.
  - Digit 0 is never blanked.
  - Dash digits (>9) count as non-zero.
- LZ_BLANK_EN undefined: every digit is always driven, including leading zeros.

## Test plan
- Reset check, SCAN_DIV=4: hold rst low, then release.
  - seg=7F, an=F, pending=0 until edge 4.
  - Then an=E, seg=40 (digit 0 shows "0").
- Load 16'h1234 once.
  - pending=1 until the next boundary.
  - The following frame scans an=E/seg=19, D/30, B/24, 7/79, and pending returns to 0.
- Tear-free swap: load 16'h5678 while idx=1.
  - The remaining digits 2,3 of the current frame still show the old word.
  - The new word appears starting at the next digit 0.
  - A second load of 16'h9999 before the boundary: 9999 is displayed.
- Load coinciding with the boundary edge: digit 0 shows the new value in that same frame, and pending stays 0.
- Load 16'h00A7.
  - Digit 1 shows dash (seg=3F), digit 0 shows 78, bcd_err=1.
  - Then load 16'h0007: bcd_err clears at the swap.
- With LZ_BLANK_EN, load 16'h0007: digits 3,2,1 drive an=F/seg=7F and digit 0 shows 78. Assert rst mid-frame: outputs are dark immediately.
